// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone arbiter/interconnect:
//   - wb_state_e : transaction FSM states (IDLE -> BUSY -> DONE)
//   - SEL_W      : width of the slave-select field taken from the address
//   - MIDX_W     : width of a master index (up to four masters)
//   - ERR_RDATA  : read data returned to a master on error/idle
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int          SEL_W     = 4;
    localparam int          MIDX_W    = 2;
    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Purely combinational round-robin arbiter. Starting at rr_ptr_i and wrapping
// around, the first requesting master wins.
// Ports:
//   req_i       in  N_MASTERS  request per master
//   rr_ptr_i    in  MIDX_W     highest-priority master index this round
//   gnt_o       out N_MASTERS  one-hot grant (all zero when no request)
//   gnt_idx_o   out MIDX_W     binary index of the granted master
//   gnt_valid_o out 1          at least one request present
// -----------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int N_MASTERS = 2
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [MIDX_W-1:0]    rr_ptr_i,
    output logic [N_MASTERS-1:0] gnt_o,
    output logic [MIDX_W-1:0]    gnt_idx_o,
    output logic                 gnt_valid_o
);

    int   cand;
    int   win;
    logic found;

    always_comb begin
        cand  = 0;
        win   = 0;
        found = 1'b0;
        // Walk the masters in priority order rr_ptr, rr_ptr+1, ... (mod N).
        // The inner loop compares against a constant index so no variable
        // bit-select into req_i is needed.
        for (int off = 0; off < N_MASTERS; off++) begin
            cand = int'(rr_ptr_i) + off;
            if (cand >= N_MASTERS) begin
                cand = cand - N_MASTERS;
            end
            for (int i = 0; i < N_MASTERS; i++) begin
                if (!found && (i == cand) && req_i[i]) begin
                    found = 1'b1;
                    win   = i;
                end
            end
        end
        gnt_valid_o = found;
        gnt_idx_o   = MIDX_W'(win);
        for (int i = 0; i < N_MASTERS; i++) begin
            gnt_o[i] = found && (i == win);
        end
    end

endmodule

// File: rtl/wb_arb_intercon.sv
// -----------------------------------------------------------------------------
// wb_arb_intercon
// Shared-bus Wishbone interconnect: N_MASTERS masters arbitrated round-robin
// onto one bus, decoded to N_SLAVES windows by ADDR[SEL_LSB+3:SEL_LSB].
// One transaction at a time: IDLE (arbitrate, latch decode) -> BUSY (forward
// combinationally until ACK / ERR / abort) -> DONE (one quiet cycle, advance
// round-robin pointer) -> IDLE.
//
// Optional feature: define WB_TIMEOUT_EN to add a BUSY-cycle watchdog that
// terminates with m_ERR after TIMEOUT_CYC cycles without ACK. Without it,
// BUSY waits indefinitely for ACK or master abort.
//
// Ports (master k / slave k packed at [32k+31:32k] or bit k):
//   clk      in  1              sole clock
//   reset    in  1              asynchronous active-low reset
//   m_STB    in  N_MASTERS      master strobe
//   m_WE     in  N_MASTERS      master write enable
//   m_ADDR   in  32*N_MASTERS   master address
//   m_DAT_I  in  32*N_MASTERS   master write data
//   m_DAT_O  out 32*N_MASTERS   read data to masters
//   m_ACK    out N_MASTERS      acknowledge to masters
//   m_ERR    out N_MASTERS      error termination to masters
//   s_STB    out N_SLAVES       per-slave strobe
//   s_WE     out 1              write enable to slaves
//   s_ADDR   out 32             address to slaves
//   s_DAT_O  out 32             write data to slaves
//   s_DAT_I  in  32*N_SLAVES    read data from slaves
//   s_ACK    in  N_SLAVES       acknowledge from slaves
// -----------------------------------------------------------------------------
module wb_arb_intercon
    import wb_pkg::*;
#(
    parameter int N_MASTERS   = 2,
    parameter int N_SLAVES    = 8,
    parameter int SEL_LSB     = 28,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_MASTERS-1:0]    m_STB,
    input  logic [N_MASTERS-1:0]    m_WE,
    input  logic [32*N_MASTERS-1:0] m_ADDR,
    input  logic [32*N_MASTERS-1:0] m_DAT_I,
    output logic [32*N_MASTERS-1:0] m_DAT_O,
    output logic [N_MASTERS-1:0]    m_ACK,
    output logic [N_MASTERS-1:0]    m_ERR,
    output logic [N_SLAVES-1:0]     s_STB,
    output logic                    s_WE,
    output logic [31:0]             s_ADDR,
    output logic [31:0]             s_DAT_O,
    input  logic [32*N_SLAVES-1:0]  s_DAT_I,
    input  logic [N_SLAVES-1:0]     s_ACK
);

    wb_state_e          state_q, state_d;
    logic [MIDX_W-1:0]  grant_q, grant_d;
    logic [MIDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
`ifdef WB_TIMEOUT_EN
    logic [15:0]        tmo_q, tmo_d;
`endif

    logic [N_MASTERS-1:0] arb_gnt;
    logic [MIDX_W-1:0]    arb_idx;
    logic                 arb_valid;
    logic [SEL_W-1:0]     arb_sel;

    logic        sel_stb, sel_we;
    logic [31:0] sel_addr, sel_wdat;
    logic        sel_ack;
    logic [31:0] sel_rdat;
    logic        slave_ok;

    logic        fwd;         // bus driven toward slave idx_q this cycle
    logic        ack_to_m;
    logic        err_to_m;

    wb_rr_arbiter #(
        .N_MASTERS (N_MASTERS)
    ) u_arb (
        .req_i       (m_STB),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_o       (arb_gnt),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_valid)
    );

    // Slave-select field of the master the arbiter is picking right now.
    always_comb begin
        arb_sel = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (arb_gnt[i]) begin
                arb_sel = m_ADDR[32*i + SEL_LSB +: SEL_W];
            end
        end
    end

    // Bus signals of the master holding the grant.
    always_comb begin
        sel_stb  = 1'b0;
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_wdat = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q == MIDX_W'(i)) begin
                sel_stb  = m_STB[i];
                sel_we   = m_WE[i];
                sel_addr = m_ADDR[32*i +: 32];
                sel_wdat = m_DAT_I[32*i +: 32];
            end
        end
    end

    // Response of the decoded slave; windows beyond N_SLAVES have no slave.
    always_comb begin
        sel_ack = 1'b0;
        sel_rdat = ERR_RDATA;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_ack  = s_ACK[i];
                sel_rdat = s_DAT_I[32*i +: 32];
            end
        end
    end

    assign slave_ok = (int'(idx_q) < N_SLAVES);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        fwd      = 1'b0;
        ack_to_m = 1'b0;
        err_to_m = 1'b0;
`ifdef WB_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    idx_d   = arb_sel;
                    state_d = ST_BUSY;
`ifdef WB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (!sel_stb) begin
                    // Master withdrew: quietly abandon the cycle.
                    state_d = ST_DONE;
                end else if (!slave_ok) begin
                    err_to_m = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    fwd = 1'b1;
                    if (sel_ack) begin
                        // ACK takes priority over a watchdog expiring now.
                        ack_to_m = 1'b1;
                        state_d  = ST_DONE;
                    end
`ifdef WB_TIMEOUT_EN
                    else if (tmo_q == 16'(TIMEOUT_CYC - 1)) begin
                        // This is the TIMEOUT_CYC-th BUSY cycle without ACK.
                        err_to_m = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
`endif
                end
            end
            ST_DONE: begin
                rr_ptr_d = (grant_q == MIDX_W'(N_MASTERS - 1)) ? '0 : grant_q + MIDX_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Shared slave-side bus: zero whenever not forwarding.
    assign s_WE    = fwd & sel_we;
    assign s_ADDR  = fwd ? sel_addr : '0;
    assign s_DAT_O = fwd ? sel_wdat : '0;

    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
        assign s_STB[gi] = fwd && (idx_q == SEL_W'(gi));
    end

    // Only the granted master ever sees a response; everyone else reads zero.
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
        logic is_gnt;
        assign is_gnt                 = (grant_q == MIDX_W'(gi));
        assign m_ACK[gi]              = ack_to_m && is_gnt;
        assign m_ERR[gi]              = err_to_m && is_gnt;
        assign m_DAT_O[32*gi +: 32]   = (fwd && is_gnt) ? sel_rdat : ERR_RDATA;
    end

endmodule

// File: doc/wb_arb_intercon.md
WB_ARB_INTERCON -- requirements
Module: wb_arb_intercon

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of bus masters (1..4).
REQ-002 SHALL have parameter N_SLAVES, default 8, number of slave windows (1..16).
REQ-003 SHALL have parameter SEL_LSB, default 28, LSB of 4-bit slave-select field ADDR[SEL_LSB+3:SEL_LSB].
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, max cycles waiting for slave ACK (1..65535).
REQ-005 SHALL have ports: clk  in  1  sole clock; reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: m_STB  in  N_MASTERS; m_WE  in  N_MASTERS; m_ADDR  in  32*N_MASTERS; m_DAT_I  in  32*N_MASTERS  write data.
REQ-007 SHALL have ports: m_DAT_O  out  32*N_MASTERS  read data; m_ACK  out  N_MASTERS; m_ERR  out  N_MASTERS  error terminate.
REQ-008 SHALL have ports: s_STB  out  N_SLAVES; s_WE  out  1; s_ADDR  out  32; s_DAT_O  out  32  write data; s_DAT_I  in  32*N_SLAVES; s_ACK  in  N_SLAVES.
REQ-009 SHALL pack master/slave k into bits [32k+31:32k] (or bit k for 1-bit buses).

Function
REQ-010 SHALL implement FSM IDLE, BUSY, DONE.
REQ-011 IDLE: when any m_STB high, SHALL register grant by round-robin starting at pointer rr_ptr, latch slave index from granted m_ADDR, go BUSY next cycle.
REQ-012 BUSY: SHALL drive s_STB[idx]=m_STB[grant], s_WE, s_ADDR, s_DAT_O from granted master combinationally; all other s_STB low.
REQ-013 BUSY: m_ACK[grant]=s_ACK[idx] and m_DAT_O[grant]=s_DAT_I[idx] combinationally, same cycle; on ACK go DONE.
REQ-014 DONE: one idle cycle, all s_STB/m_ACK/m_ERR low, rr_ptr<=grant+1 mod N_MASTERS, then IDLE.
REQ-015 Latency: m_STB at cycle 0 in IDLE -> s_STB at cycle 1; single-cycle slave -> m_ACK at cycle 1 earliest.
REQ-016 idx>=N_SLAVES in BUSY: no s_STB, m_ERR[grant] high one cycle, m_DAT_O=0, go DONE.
REQ-017 Granted master drops m_STB in BUSY: SHALL abort, s_STB low same cycle, go DONE, no ACK/ERR.
REQ-018 Non-granted masters SHALL see m_ACK=0, m_ERR=0, m_DAT_O=0 and wait.
REQ-019 Simultaneous requests: lowest index at or above rr_ptr (wrapping) wins; N_MASTERS=1 always grants 0.

Reset
REQ-020 reset low SHALL asynchronously force IDLE, rr_ptr=0, grant=0, timeout counter=0; all outputs 0 immediately, including mid-transaction.
REQ-021 First grant after reset release SHALL be at the first rising clk edge with reset high.

Configuration
REQ-022 With WB_TIMEOUT_EN defined: counter SHALL clear on entering BUSY, increment each BUSY cycle without ACK; reaching TIMEOUT_CYC SHALL assert m_ERR[grant] one cycle, drop s_STB, go DONE.
REQ-023 ACK in the same cycle as timeout expiry SHALL win (ACK, no ERR).
REQ-024 Without WB_TIMEOUT_EN: no counter logic; BUSY waits indefinitely for ACK or abort.

Structure
REQ-025 Package wb_pkg SHALL hold FSM state typedef, SEL_W=4, and ERR read-data constant (0).
REQ-026 Round-robin grant logic SHALL be sub-module wb_rr_arbiter (req, rr_ptr -> one-hot grant, index).
REQ-027 Decode, FSM, muxing, timeout SHALL remain in wb_arb_intercon.

Verification
REQ-028 M0 read ADDR 0x1000_0004, slave1 ACKs 1 cycle after s_STB with 0xCAFE_F00D -> m_ACK[0] with m_DAT_O[0]=0xCAFE_F00D, s_STB=8'b0000_0010.
REQ-029 M0,M1 request same cycle after reset -> M0 served first, then M1 after DONE; repeated simultaneous -> alternates.
REQ-030 M1 write ADDR 0xF000_0000 with N_SLAVES=8 -> no s_STB, m_ERR[1] one cycle, then DONE.
REQ-031 WB_TIMEOUT_EN, TIMEOUT_CYC=4, slave never ACKs -> m_ERR after 4 BUSY cycles; ACK on 4th cycle -> ACK only.
REQ-032 reset low mid-BUSY -> all s_STB/m_ACK low immediately; after release, new request granted to M0.
